get_fsm: RTL and testbench

- Read-side counterpart of the controller's upsert sub-FSM.
- Drives key lookup and entry select for a GET command, then captures the hit entry's value into a local register.
- Streams that value to the response path in BEAT_WIDTH beats using a valid/ready handshake.
- Reports completion or error to the main controller through the shared sub-command struct (done/error), like the other sub-FSMs.

---
 rtl/cache_cfg_pkg.sv | 5 +
 rtl/ctrl_types_pkg.sv | 7 +
 rtl/get_fsm.sv | 132 +++++++++++++
 tb/tb_get_fsm.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_cfg_pkg.sv
// Cache geometry shared by the controller and its sub-FSMs.
package cache_cfg_pkg;
    localparam int unsigned NUM_ENTRIES = 8;
    localparam int unsigned VALUE_WIDTH = 32;
endpackage

// File: rtl/ctrl_types_pkg.sv
// Types shared between the main controller and its sub-FSMs.
package ctrl_types_pkg;
    typedef struct packed {
        logic done;
        logic error;
    } sub_cmd_t;
endpackage

// File: rtl/get_fsm.sv
// GET sub-FSM: looks up a key's entry, captures its value and streams it out
// LSB beat first over a valid/ready handshake, then reports done or error.
module get_fsm #(
    parameter int unsigned NUM_ENTRIES = cache_cfg_pkg::NUM_ENTRIES,
    parameter int unsigned VALUE_WIDTH = cache_cfg_pkg::VALUE_WIDTH,
    parameter int unsigned BEAT_WIDTH  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     enter,
    input  logic                     hit,
    input  logic [NUM_ENTRIES-1:0]   used,
    input  logic [NUM_ENTRIES-1:0]   idx_in,
    input  logic [VALUE_WIDTH-1:0]   value_in,
    output logic                     select_out,
    output logic                     read_out,
    output logic [NUM_ENTRIES-1:0]   idx_out,
    output logic [BEAT_WIDTH-1:0]    rd_data,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic                     rd_last,
    output ctrl_types_pkg::sub_cmd_t cmd
);

    localparam int unsigned NUM_BEATS = VALUE_WIDTH / BEAT_WIDTH;
    localparam int unsigned CNT_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_BEATS - 1);

    if ((VALUE_WIDTH % BEAT_WIDTH) != 0) begin : g_bad_beat_width
        $error("get_fsm: VALUE_WIDTH must be a multiple of BEAT_WIDTH");
    end

    typedef enum logic [1:0] {
        GET_ST_IDLE,
        GET_ST_LOOKUP,
        GET_ST_STREAM
    } get_state_e;

    get_state_e             state_q, state_d;
    logic [VALUE_WIDTH-1:0] value_q, value_d;
    logic [NUM_ENTRIES-1:0] idx_q, idx_d;
    logic [CNT_W-1:0]       beat_cnt_q, beat_cnt_d;

    logic                   lookup_ok;
    logic [BEAT_WIDTH-1:0]  beat_data;

    // A lookup is usable only for a single, occupied, matching entry.
    assign lookup_ok = hit && $onehot(idx_in) && ((idx_in & used) != '0);

    always_comb begin
        beat_data = '0;
        for (int unsigned b = 0; b < NUM_BEATS; b++) begin
            if (beat_cnt_q == CNT_W'(b)) begin
                beat_data = value_q[b*BEAT_WIDTH +: BEAT_WIDTH];
            end
        end
    end

    // Next-state, register updates and combinational outputs.
    always_comb begin
        state_d    = state_q;
        value_d    = value_q;
        idx_d      = idx_q;
        beat_cnt_d = beat_cnt_q;
        select_out = 1'b0;
        read_out   = 1'b0;
        idx_out    = '0;
        rd_data    = '0;
        rd_valid   = 1'b0;
        rd_last    = 1'b0;
        cmd        = '0;

        if (enter) begin
            state_d    = GET_ST_LOOKUP;
            beat_cnt_d = '0;
        end else if (en) begin
            case (state_q)
                GET_ST_IDLE: begin
                    state_d = GET_ST_IDLE;
                end
                GET_ST_LOOKUP: begin
                    if (lookup_ok) begin
                        select_out = 1'b1;
                        read_out   = 1'b1;
                        idx_out    = idx_in;
                        value_d    = value_in;
                        idx_d      = idx_in;
                        beat_cnt_d = '0;
                        state_d    = GET_ST_STREAM;
                    end else begin
                        cmd.error  = 1'b1;
                        state_d    = GET_ST_IDLE;
                    end
                end
                GET_ST_STREAM: begin
                    rd_valid = 1'b1;
                    rd_data  = beat_data;
                    rd_last  = (beat_cnt_q == LAST_BEAT);
                    idx_out  = idx_q;
                    if (rd_ready) begin
                        if (beat_cnt_q == LAST_BEAT) begin
                            cmd.done   = 1'b1;
                            beat_cnt_d = '0;
                            state_d    = GET_ST_IDLE;
                        end else begin
                            beat_cnt_d = beat_cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = GET_ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= GET_ST_IDLE;
            value_q    <= '0;
            idx_q      <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            value_q    <= value_d;
            idx_q      <= idx_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

endmodule

// File: tb/tb_get_fsm.sv
// Scoreboard bench for get_fsm: a 4-beat instance and a 1-beat instance share
// stimulus; expectations are derived from each GET request and checked by a monitor.
module tb_get_fsm;
    import ctrl_types_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        enter = 1'b0;
    logic        hit = 1'b0;
    logic        rd_ready = 1'b0;
    logic [7:0]  used = '0;
    logic [7:0]  idx_in = '0;
    logic [31:0] value_in = '0;

    logic        sel0, rdo0, v0, last0;
    logic [7:0]  idx0, data0;
    sub_cmd_t    cmd0;
    logic        sel1, rdo1, v1, last1;
    logic [7:0]  idx1;
    logic [31:0] data1;
    sub_cmd_t    cmd1;

    get_fsm #(.NUM_ENTRIES(8), .VALUE_WIDTH(32), .BEAT_WIDTH(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .enter(enter), .hit(hit), .used(used),
        .idx_in(idx_in), .value_in(value_in), .select_out(sel0), .read_out(rdo0),
        .idx_out(idx0), .rd_data(data0), .rd_valid(v0), .rd_ready(rd_ready),
        .rd_last(last0), .cmd(cmd0));

    get_fsm #(.NUM_ENTRIES(8), .VALUE_WIDTH(32), .BEAT_WIDTH(32)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .enter(enter), .hit(hit), .used(used),
        .idx_in(idx_in), .value_in(value_in), .select_out(sel1), .read_out(rdo1),
        .idx_out(idx1), .rd_data(data1), .rd_valid(v1), .rd_ready(rd_ready),
        .rd_last(last1), .cmd(cmd1));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct packed { logic [31:0] data; logic last; logic [7:0] idx; int cyc; } beat_t;
    typedef struct packed { logic is_err; int cyc; } evt_t;
    typedef struct packed { logic [7:0] idx; int cyc; } sel_t;

    beat_t exp_beat[2][$];
    evt_t  exp_evt[2][$];
    sel_t  exp_sel[2][$];

    // Stimulus context for the current request.
    int          t0 = 0;
    int          s_beat = 99, s_len = 0, f_beat = 99, f_len = 0;
    bit          rnd = 1'b0;
    logic [31:0] cur_val = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_cyc(input string name, input int exp_c);
        if (exp_c >= 0) chk(name, 64'(cyc), 64'(exp_c));
    endtask

    task automatic unexpected(input string name);
        tests++;
        fails++;
        $display("FAIL %s: got unexpected output expected none (cycle %0d)", name, cyc);
    endtask

    task automatic mon(input int d, input logic s, input logic r, input logic [7:0] ix,
                       input logic [31:0] dat, input logic v, input logic l,
                       input logic dn, input logic er);
        beat_t b;
        evt_t  e;
        sel_t  q;
        if (!rst_n || !en) begin
            chk($sformatf("d%0d quiet", d), {56'd0, s, r, v, l, dn, er, (ix != 0), 1'b0}, 64'd0);
            return;
        end
        if (enter) begin
            chk($sformatf("d%0d enter no cmd", d), {62'd0, dn, er}, 64'd0);
            return;
        end
        if (s || r) begin
            if (exp_sel[d].size() == 0) unexpected($sformatf("d%0d select", d));
            else begin
                q = exp_sel[d].pop_front();
                chk($sformatf("d%0d select/read", d), {62'd0, s, r}, 64'd3);
                chk($sformatf("d%0d lookup idx", d), 64'(ix), 64'(q.idx));
                chk_cyc($sformatf("d%0d lookup cycle", d), q.cyc);
            end
        end
        if (v) begin
            if (exp_beat[d].size() == 0) unexpected($sformatf("d%0d beat", d));
            else if (rd_ready) begin
                b = exp_beat[d].pop_front();
                chk($sformatf("d%0d beat data", d), 64'(dat), 64'(b.data));
                chk($sformatf("d%0d beat last", d), 64'(l), 64'(b.last));
                chk($sformatf("d%0d stream idx", d), 64'(ix), 64'(b.idx));
                chk_cyc($sformatf("d%0d beat cycle", d), b.cyc);
            end else begin
                b = exp_beat[d][0];
                chk($sformatf("d%0d held data", d), 64'(dat), 64'(b.data));
            end
        end
        if (dn || er) begin
            chk($sformatf("d%0d done&error", d), 64'(dn & er), 64'd0);
            if (exp_evt[d].size() == 0) unexpected($sformatf("d%0d cmd", d));
            else begin
                e = exp_evt[d].pop_front();
                chk($sformatf("d%0d cmd kind(error)", d), 64'(er), 64'(e.is_err));
                chk_cyc($sformatf("d%0d cmd cycle", d), e.cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, sel0, rdo0, idx0, {24'd0, data0}, v0, last0, cmd0.done, cmd0.error);
        mon(1, sel1, rdo1, idx1, data1, v1, last1, cmd1.done, cmd1.error);
    end

    task automatic apply();
        int c = cyc;
        if (rnd) begin
            en       = ($urandom_range(7) != 0);
            rd_ready = ($urandom_range(3) != 0);
            value_in = cur_val;
        end else begin
            en       = !(f_len > 0 && c >= t0 + 2 + f_beat && c < t0 + 2 + f_beat + f_len);
            rd_ready = !(s_len > 0 && c >= t0 + 2 + s_beat && c < t0 + 2 + s_beat + s_len);
            value_in = (c > t0 + 1) ? $urandom : cur_val;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        enter = 1'b0;
        apply();
    endtask

    task automatic flush(input int d);
        exp_beat[d].delete();
        exp_evt[d].delete();
        exp_sel[d].delete();
    endtask

    // Issue a GET and push what the spec says each instance must produce.
    task automatic start(input logic [31:0] val, input logic [7:0] u, input logic [7:0] ix,
                         input logic h, input int sb, input int sl, input int fb, input int fl,
                         input bit r, input bit abort);
        bit    ok;
        int    nb, bw, bc;
        beat_t b;
        evt_t  e;
        sel_t  q;
        @(posedge clk);
        #1;
        if (abort) flush(0);
        t0 = cyc; cur_val = val; used = u; idx_in = ix; hit = h;
        s_beat = sb; s_len = sl; f_beat = fb; f_len = fl; rnd = r;
        enter = 1'b1;
        apply();
        ok = h && ($countones(ix) == 1) && ((ix & u) != 8'd0);
        for (int d = 0; d < 2; d++) begin
            nb = (d == 0) ? 4 : 1;
            bw = (d == 0) ? 8 : 32;
            if (ok) begin
                q.idx = ix; q.cyc = r ? -1 : t0 + 1;
                exp_sel[d].push_back(q);
                for (int i = 0; i < nb; i++) begin
                    bc = t0 + 2 + i + ((i >= sb) ? sl : 0) + ((i >= fb) ? fl : 0);
                    b.data = (d == 0) ? ((val >> (8 * i)) & 32'hFF) : val;
                    b.last = (i == nb - 1);
                    b.idx  = ix;
                    b.cyc  = r ? -1 : bc;
                    exp_beat[d].push_back(b);
                    if (i == nb - 1) begin
                        e.is_err = 1'b0; e.cyc = r ? -1 : bc;
                        exp_evt[d].push_back(e);
                    end
                end
                if (bw == 0) e.cyc = 0;
            end else begin
                e.is_err = 1'b1; e.cyc = r ? -1 : t0 + 1;
                exp_evt[d].push_back(e);
            end
        end
    endtask

    function automatic int pending();
        int n = 0;
        for (int d = 0; d < 2; d++) n += exp_beat[d].size() + exp_evt[d].size() + exp_sel[d].size();
        return n;
    endfunction

    task automatic finish_tx();
        int n = 0;
        while (pending() != 0 && n < 300) begin
            step();
            n++;
        end
        step();
        if (pending() != 0) begin
            tests++;
            fails++;
            $display("FAIL timeout: got %0d pending expectations expected 0 (cycle %0d)", pending(), cyc);
            flush(0);
            flush(1);
        end
        step();
    endtask

    initial begin
        logic [7:0] rix, ru;
        int         k;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        en = 1'b1;
        rd_ready = 1'b1;
        step();

        // Nominal hit, then the three flavours of bad lookup.
        start(32'hDEADBEEF, 8'h10, 8'h10, 1'b1, 99, 0, 99, 0, 1'b0, 1'b0); finish_tx();
        start(32'hDEADBEEF, 8'h10, 8'h10, 1'b0, 99, 0, 99, 0, 1'b0, 1'b0); finish_tx();
        start(32'hDEADBEEF, 8'h10, 8'h18, 1'b1, 99, 0, 99, 0, 1'b0, 1'b0); finish_tx();
        start(32'hDEADBEEF, 8'h10, 8'h01, 1'b1, 99, 0, 99, 0, 1'b0, 1'b0); finish_tx();
        start(32'hDEADBEEF, 8'h00, 8'h00, 1'b1, 99, 0, 99, 0, 1'b0, 1'b0); finish_tx();

        // Backpressure on beat 1, then an enable freeze at beat 2.
        start(32'hDEADBEEF, 8'h10, 8'h10, 1'b1, 1, 3, 99, 0, 1'b0, 1'b0); finish_tx();
        start(32'hDEADBEEF, 8'h10, 8'h10, 1'b1, 99, 0, 2, 2, 1'b0, 1'b0); finish_tx();

        // Restart at beat 1 with a new value.
        start(32'h11223344, 8'h84, 8'h04, 1'b1, 99, 0, 99, 0, 1'b0, 1'b0);
        step(); step();
        start(32'hCAFEF00D, 8'h81, 8'h80, 1'b1, 99, 0, 99, 0, 1'b0, 1'b1);
        finish_tx();

        // Reset at beat 2: no further output, in particular no done.
        start(32'h55667788, 8'h02, 8'h02, 1'b1, 99, 0, 99, 0, 1'b0, 1'b0);
        step(); step(); step();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        flush(0);
        flush(1);
        step();
        rst_n = 1'b1;
        repeat (6) step();

        // Randomised requests with random enable and backpressure.
        for (int t = 0; t < 40; t++) begin
            k = $urandom_range(9);
            rix = 8'(1) << $urandom_range(7);
            if (k == 0) rix = 8'h00;
            else if (k == 1) rix = 8'($urandom);
            ru = 8'($urandom) | ((k > 4) ? rix : 8'h00);
            start($urandom, ru, rix, ($urandom_range(9) != 0), 99, 0, 99, 0, 1'b1, 1'b0);
            finish_tx();
            rnd = 1'b0;
        end
        rnd = 1'b0;
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
